// File: rtl/chan_scanner_pkg.sv
// Shared types and constants for the channel scanner and the 6-to-1 mux stage it drives.
package chan_scan_pkg;

    localparam int NUM_CH_DEF = 6;
    localparam int DW_DEF     = 4;
    localparam int SEL_W      = 3;

    // Out-of-range select code: the mux drives zero while the scanner is parked here
    localparam logic [SEL_W-1:0] SEL_IDLE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/chan_scanner_pick.sv
// chan_pick: combinational finder for the lowest enabled channel, either from
// channel 0 (from_start_i) or strictly above the current channel.
module chan_pick
    import chan_scan_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    input  logic              from_start_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              found_o
);

    // Descending scan so the lowest qualifying channel is the last one written
    always_comb begin
        next_o  = SEL_IDLE;
        found_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_start_i || (i > int'(cur_i)))) begin
                next_o  = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_scanner.sv
// chan_scanner: steps the mux select through enabled channels, settles, samples and
// hands each sample out on a valid/ready port. CHAN_SCANNER_CONTINUOUS_EN makes it wrap forever.
module chan_scanner
    import chan_scan_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DW      = DW_DEF,
    parameter int DWELL_W = 4
) (
    input  logic               clk_i,
    input  logic               aresetn_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [NUM_CH-1:0]  ch_mask_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [SEL_W-1:0]   sel_o,
    input  logic [DW-1:0]      mux_out_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DW-1:0]      out_data_o,
    output logic [SEL_W-1:0]   out_ch_o,
    output logic               busy_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               valid_q, valid_d;
    logic [DW-1:0]      data_q, data_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               done_q, done_d;

    logic [NUM_CH-1:0]  first_mask;
    logic [SEL_W-1:0]   first_ch, adv_ch;
    logic               first_found, adv_found;

    // In IDLE the first channel comes from the live mask being latched; otherwise from the latched one
    assign first_mask = (state_q == ST_IDLE) ? ch_mask_i : mask_q;

    chan_pick #(.NUM_CH(NUM_CH)) u_pick_first (
        .mask_i       (first_mask),
        .cur_i        (sel_q),
        .from_start_i (1'b1),
        .next_o       (first_ch),
        .found_o      (first_found)
    );

    chan_pick #(.NUM_CH(NUM_CH)) u_pick_adv (
        .mask_i       (mask_q),
        .cur_i        (sel_q),
        .from_start_i (1'b0),
        .next_o       (adv_ch),
        .found_o      (adv_found)
    );

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    mask_d  = ch_mask_i;
                    dwell_d = dwell_i;
                    if (first_found) begin
                        sel_d   = first_ch;
                        cnt_d   = dwell_i;
                        state_d = ST_SETTLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_SETTLE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_IDLE;
                    valid_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    data_d  = mux_out_i;
                    ch_d    = sel_q;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // A handshake coincident with stop still completes downstream; stop only kills what follows
                if (stop_i) begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_IDLE;
                    valid_d = 1'b0;
                end else if (valid_q && out_ready_i) begin
                    valid_d = 1'b0;
                    if (adv_found) begin
                        sel_d   = adv_ch;
                        cnt_d   = dwell_q;
                        state_d = ST_SETTLE;
                    end else begin
                        done_d = 1'b1;
`ifdef CHAN_SCANNER_CONTINUOUS_EN
                        sel_d   = first_ch;
                        cnt_d   = dwell_q;
                        state_d = ST_SETTLE;
`else
                        sel_d   = SEL_IDLE;
                        state_d = ST_IDLE;
`endif
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign sel_o       = sel_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_ch_o    = ch_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;

endmodule
